// File: rtl/flow_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// flow_ctrl_fsm_pkg
// Shared definitions for the PCIe FIFO flow-control block: the controller
// state encoding, the number of virtual channels, the threshold values the
// FIFOs see straight out of reset, and a threshold sanity helper.
// ---------------------------------------------------------------------------
package flow_ctrl_fsm_pkg;

    // Controller states. The encoding is visible on the 'state' port, so the
    // numeric values are fixed rather than left to the tools.
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } fc_state_t;

    // Number of virtual-channel FIFOs sharing the downstream output.
    localparam int N_VC = 4;

    // Thresholds presented to the FIFOs before software has loaded any.
    localparam int UMB_AF_RST = 6;
    localparam int UMB_AE_RST = 1;

    // A threshold pair is only usable when almost-empty sits strictly below
    // almost-full; otherwise a FIFO could be both at once.
    function automatic logic thresholds_valid(input int unsigned af, input int unsigned ae);
        return (ae < af);
    endfunction

endpackage

// File: rtl/flow_ctrl_fsm_rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
// Four-way round-robin arbiter. Starting at 'ptr' and wrapping, it grants the
// first requester it finds. Purely combinational; the caller owns the pointer
// register and advances it using gnt_idx when 'upd' is high.
//
// Ports
//   req      in   4  request per channel
//   ptr      in   2  channel with highest priority this cycle
//   en       in   1  arbitration allowed this cycle
//   gnt      out  4  one-hot grant, or zero when nothing is granted
//   gnt_idx  out  2  index of the granted channel (ptr when no grant)
//   upd      out  1  a grant was issued, so the pointer should move past it
// ---------------------------------------------------------------------------
module rr_arb4
    import flow_ctrl_fsm_pkg::*;
(
    input  logic [N_VC-1:0] req,
    input  logic [1:0]      ptr,
    input  logic            en,
    output logic [N_VC-1:0] gnt,
    output logic [1:0]      gnt_idx,
    output logic            upd
);

    logic [1:0] cand;

    // Walk the channels in priority order from ptr. The 2-bit sum wraps
    // naturally, giving the modulo-4 scan. Only the first hit is taken, so
    // at most one grant bit can be set.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        upd     = 1'b0;
        cand    = ptr;
        for (int k = 0; k < N_VC; k++) begin
            cand = ptr + 2'(k);
            if (en && !upd && req[cand]) begin
                upd     = 1'b1;
                gnt_idx = cand;
            end
        end
        if (upd) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// flow_ctrl_fsm
// Main control FSM and pop scheduler for the PCIe FIFO datapath. Drains the
// input FIFO (FIFO4) into the four virtual-channel FIFOs (FIFO0-3) while
// honouring their almost-full flags, and round-robins the single downstream
// output among FIFO0-3. The pop strobes and IDLE flag feed the per-FIFO word
// counters directly, so the pops are zero-latency decodes of the current
// state and flags.
//
// Ports
//   CLK          in   1      clock, all state on rising edge
//   reset        in   1      asynchronous, active-low reset
//   init         in   1      request to enter/stay in INIT and load thresholds
//   umb_af_in    in   UMB_W  almost-full threshold to load
//   umb_ae_in    in   UMB_W  almost-empty threshold to load
//   fifo4_empty  in   1      FIFO4 empty
//   fifo4_dest   in   2      destination VC of the FIFO4 head word
//   fifo_af      in   4      almost-full flags, FIFO0-3
//   fifo_empty   in   4      empty flags, FIFO0-3
//   out_ready    in   1      downstream accepts one word this cycle
//   pop4         out  1      pop FIFO4 (and push into FIFO[fifo4_dest])
//   pop          out  4      one-hot or zero pop to FIFO0-3
//   umb_af       out  UMB_W  latched almost-full threshold
//   umb_ae       out  UMB_W  latched almost-empty threshold
//   IDLE         out  1      high while in IDLE
//   state        out  2      current state encoding
//   cfg_err      out  1      last INIT exit attempt saw invalid thresholds
//   blocked      out  1      FIFO4 head stalled for BLOCK_LIMIT cycles
// ---------------------------------------------------------------------------
module flow_ctrl_fsm
    import flow_ctrl_fsm_pkg::*;
#(
    parameter int UMB_W       = 3,
    parameter int BLOCK_LIMIT = 15
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             init,
    input  logic [UMB_W-1:0] umb_af_in,
    input  logic [UMB_W-1:0] umb_ae_in,
    input  logic             fifo4_empty,
    input  logic [1:0]       fifo4_dest,
    input  logic [N_VC-1:0]  fifo_af,
    input  logic [N_VC-1:0]  fifo_empty,
    input  logic             out_ready,
    output logic             pop4,
    output logic [N_VC-1:0]  pop,
    output logic [UMB_W-1:0] umb_af,
    output logic [UMB_W-1:0] umb_ae,
    output logic             IDLE,
    output logic [1:0]       state,
    output logic             cfg_err,
    output logic             blocked
);

    localparam int              CNT_W   = $clog2(BLOCK_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_LIMIT);

    fc_state_t       cur_state;
    logic [1:0]      rr_ptr;
    logic [CNT_W-1:0] block_cnt;
    logic [CNT_W-1:0] block_cnt_next;

    logic            is_active;
    logic            all_empty;
    logic            arb_upd;
    logic [1:0]      arb_idx;
    logic [N_VC-1:0] arb_gnt;

    // Status decodes. Because these come from the state register, an
    // asynchronous reset forces every pop low immediately, so no transfer
    // is left half done.
    assign is_active = (cur_state == ST_ACTIVE);
    assign all_empty = fifo4_empty & (&fifo_empty);
    assign IDLE      = (cur_state == ST_IDLE);
    assign state     = cur_state;

    // FIFO4 drains whenever its head word's destination has room. The
    // destination may be popped by the arbiter in the same cycle; the FIFO
    // itself handles a simultaneous push and pop.
    assign pop4 = is_active & ~fifo4_empty & ~fifo_af[fifo4_dest];

    // Output arbitration only runs while ACTIVE and downstream is ready.
    rr_arb4 u_arb (
        .req     (~fifo_empty),
        .ptr     (rr_ptr),
        .en      (is_active & out_ready),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .upd     (arb_upd)
    );

    assign pop = arb_gnt;

    // Stall counter for the FIFO4 head. It counts consecutive ACTIVE cycles
    // in which a word is waiting but cannot move, saturates at the limit,
    // and restarts as soon as a word moves or the controller leaves ACTIVE.
    // An ACTIVE cycle with FIFO4 empty neither stalls nor moves a word, so
    // the count simply holds.
    always_comb begin
        block_cnt_next = block_cnt;
        if (!is_active || pop4) begin
            block_cnt_next = '0;
        end else if (!fifo4_empty && (block_cnt != CNT_MAX)) begin
            block_cnt_next = block_cnt + CNT_W'(1);
        end
    end

    // Single sequential block: FSM state, threshold registers, config error
    // flag, round-robin pointer and the stall counter with its flag. The
    // blocked flag is taken from the counter's next value so it rises on
    // the same edge the counter reaches the limit.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_RESET;
            umb_af    <= UMB_W'(UMB_AF_RST);
            umb_ae    <= UMB_W'(UMB_AE_RST);
            rr_ptr    <= 2'd0;
            block_cnt <= '0;
            cfg_err   <= 1'b0;
            blocked   <= 1'b0;
        end else begin
            block_cnt <= block_cnt_next;
            blocked   <= (block_cnt_next == CNT_MAX);

            if (arb_upd) begin
                rr_ptr <= arb_idx + 2'd1;
            end

            case (cur_state)
                ST_RESET: begin
                    cur_state <= ST_INIT;
                end
                ST_INIT: begin
                    umb_af <= umb_af_in;
                    umb_ae <= umb_ae_in;
                    if (!init) begin
                        if (thresholds_valid(int'(umb_af_in), int'(umb_ae_in))) begin
                            cur_state <= ST_IDLE;
                            cfg_err   <= 1'b0;
                        end else begin
                            cfg_err   <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        cur_state <= ST_INIT;
                    end else if (!all_empty) begin
                        cur_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (init) begin
                        cur_state <= ST_INIT;
                    end else if (all_empty) begin
                        cur_state <= ST_IDLE;
                    end
                end
                default: begin
                    cur_state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_flow_ctrl_fsm
// Self-checking bench for flow_ctrl_fsm: a directed vector table for the
// configuration and arbitration walk-through, hand-written sequences for the
// stall limit and a mid-operation reset, then randomized traffic compared
// against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_flow_ctrl_fsm;

    localparam int LIMIT = 15;

    logic       CLK = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] umb_af_in;
    logic [2:0] umb_ae_in;
    logic       fifo4_empty;
    logic [1:0] fifo4_dest;
    logic [3:0] fifo_af;
    logic [3:0] fifo_empty;
    logic       out_ready;
    logic       pop4;
    logic [3:0] pop;
    logic [2:0] umb_af;
    logic [2:0] umb_ae;
    logic       IDLE;
    logic [1:0] state;
    logic       cfg_err;
    logic       blocked;

    int checks = 0;
    int errors = 0;

    flow_ctrl_fsm #(.UMB_W(3), .BLOCK_LIMIT(LIMIT)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .init        (init),
        .umb_af_in   (umb_af_in),
        .umb_ae_in   (umb_ae_in),
        .fifo4_empty (fifo4_empty),
        .fifo4_dest  (fifo4_dest),
        .fifo_af     (fifo_af),
        .fifo_empty  (fifo_empty),
        .out_ready   (out_ready),
        .pop4        (pop4),
        .pop         (pop),
        .umb_af      (umb_af),
        .umb_ae      (umb_ae),
        .IDLE        (IDLE),
        .state       (state),
        .cfg_err     (cfg_err),
        .blocked     (blocked)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    typedef struct {
        logic       init;
        logic [2:0] af_in;
        logic [2:0] ae_in;
        logic       f4e;
        logic [1:0] dest;
        logic [3:0] af;
        logic [3:0] fe;
        logic       rdy;
        logic [1:0] e_state;
        logic       e_pop4;
        logic [3:0] e_pop;
        logic [2:0] e_af;
        logic [2:0] e_ae;
        logic       e_cfg;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    int m_state, m_af, m_ae, m_ptr, m_stall;
    int m_cfg, m_blocked;

    function automatic vec_t mk(input int i, input int afi, input int aei, input int f4e,
                                input int dest, input int af, input int fe, input int rdy,
                                input int st, input int p4, input int p, input int eaf,
                                input int eae, input int cfg);
        vec_t v;
        v.init = 1'(i);   v.af_in = 3'(afi); v.ae_in = 3'(aei); v.f4e = 1'(f4e);
        v.dest = 2'(dest); v.af = 4'(af);    v.fe = 4'(fe);       v.rdy = 1'(rdy);
        v.e_state = 2'(st); v.e_pop4 = 1'(p4); v.e_pop = 4'(p);
        v.e_af = 3'(eaf); v.e_ae = 3'(eae);  v.e_cfg = 1'(cfg);
        return v;
    endfunction

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive every input from one vector record.
    task automatic applyStimulus(input vec_t v);
        init        = v.init;
        umb_af_in   = v.af_in;
        umb_ae_in   = v.ae_in;
        fifo4_empty = v.f4e;
        fifo4_dest  = v.dest;
        fifo_af     = v.af;
        fifo_empty  = v.fe;
        out_ready   = v.rdy;
    endtask

    task automatic modelReset();
        m_state = 0; m_af = 6; m_ae = 1; m_ptr = 0; m_stall = 0; m_cfg = 0; m_blocked = 0;
    endtask

    // Expected pops for the current model state and the inputs now driven.
    task automatic modelExpect(output int e_pop4, output int e_pop, output int g_idx);
        bit act;
        act    = (m_state == 3);
        e_pop4 = (act && !fifo4_empty && !fifo_af[fifo4_dest]) ? 1 : 0;
        e_pop  = 0;
        g_idx  = -1;
        if (act && out_ready) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (g_idx < 0 && !fifo_empty[i]) begin
                    g_idx = i;
                    e_pop = 1 << i;
                end
            end
        end
    endtask

    // Advance the model across one rising edge.
    task automatic modelStep(input int e_pop4, input int g_idx);
        bit act;
        act = (m_state == 3);
        if (g_idx >= 0) m_ptr = (g_idx + 1) % 4;
        if (!act || e_pop4 != 0) m_stall = 0;
        else if (!fifo4_empty) m_stall = (m_stall < LIMIT) ? m_stall + 1 : LIMIT;
        m_blocked = (m_stall == LIMIT) ? 1 : 0;
        case (m_state)
            0: m_state = 1;
            1: begin
                m_af = int'(umb_af_in);
                m_ae = int'(umb_ae_in);
                if (!init) begin
                    if (int'(umb_ae_in) < int'(umb_af_in)) begin
                        m_state = 2;
                        m_cfg   = 0;
                    end else begin
                        m_cfg = 1;
                    end
                end
            end
            default: begin
                if (init) m_state = 1;
                else if (fifo4_empty && fifo_empty == 4'hF) m_state = 2;
                else m_state = 3;
            end
        endcase
    endtask

    initial begin
        int ep4, ep, gi;

        // Directed walk-through: each row is checked just before its rising edge.
        //             init af ae f4e d af fe   rdy | st p4 pop  af ae cfg
        tbl.push_back(mk(1, 5, 2, 1, 0, 0, 15, 0,   0, 0, 0,   6, 1, 0));
        tbl.push_back(mk(1, 5, 2, 1, 0, 0, 15, 0,   1, 0, 0,   6, 1, 0));
        tbl.push_back(mk(0, 5, 2, 1, 0, 0, 15, 0,   1, 0, 0,   5, 2, 0));
        tbl.push_back(mk(0, 5, 2, 1, 0, 0, 15, 0,   2, 0, 0,   5, 2, 0));
        tbl.push_back(mk(1, 2, 2, 1, 0, 0, 15, 0,   2, 0, 0,   5, 2, 0));
        tbl.push_back(mk(0, 2, 2, 1, 0, 0, 15, 0,   1, 0, 0,   5, 2, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 15, 0,   1, 0, 0,   2, 2, 1));
        tbl.push_back(mk(0, 4, 1, 0, 2, 0, 15, 0,   2, 0, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 0, 2, 0, 15, 0,   3, 1, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 0, 2, 0, 15, 0,   3, 1, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 0, 2, 0, 15, 0,   3, 1, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 2, 0, 11, 0,   3, 0, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  1,   3, 0, 1,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  1,   3, 0, 2,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  1,   3, 0, 4,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  1,   3, 0, 8,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  1,   3, 0, 1,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  0,   3, 0, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0,  1,   3, 0, 2,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 10, 1,   3, 0, 4,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 10, 1,   3, 0, 1,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 10, 1,   3, 0, 4,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 15, 1,   3, 0, 0,   4, 1, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 15, 1,   2, 0, 0,   4, 1, 0));

        // Reset held with traffic-like inputs: everything must stay quiet.
        reset = 1'b0;
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        #1;
        checkOutput("rst_state",   8'(state),   8'd0);
        checkOutput("rst_pop4",    8'(pop4),    8'd0);
        checkOutput("rst_pop",     8'(pop),     8'd0);
        checkOutput("rst_idle",    8'(IDLE),    8'd0);
        checkOutput("rst_umb_af",  8'(umb_af),  8'd6);
        checkOutput("rst_umb_ae",  8'(umb_ae),  8'd1);
        checkOutput("rst_cfg_err", 8'(cfg_err), 8'd0);
        checkOutput("rst_blocked", 8'(blocked), 8'd0);
        @(negedge CLK);
        reset = 1'b1;

        foreach (tbl[r]) begin
            applyStimulus(tbl[r]);
            #1;
            checkOutput($sformatf("row%0d_state", r),  8'(state),   8'(tbl[r].e_state));
            checkOutput($sformatf("row%0d_idle", r),   8'(IDLE),    8'(tbl[r].e_state == 2'd2));
            checkOutput($sformatf("row%0d_pop4", r),   8'(pop4),    8'(tbl[r].e_pop4));
            checkOutput($sformatf("row%0d_pop", r),    8'(pop),     8'(tbl[r].e_pop));
            checkOutput($sformatf("row%0d_umb_af", r), 8'(umb_af),  8'(tbl[r].e_af));
            checkOutput($sformatf("row%0d_umb_ae", r), 8'(umb_ae),  8'(tbl[r].e_ae));
            checkOutput($sformatf("row%0d_cfg", r),    8'(cfg_err), 8'(tbl[r].e_cfg));
            @(negedge CLK);
        end

        // FIFO4 head stuck behind almost-full FIFO2.
        applyStimulus(mk(0, 4, 1, 0, 2, 4, 15, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("blk_start_state", 8'(state), 8'd2);
        @(negedge CLK);
        for (int i = 0; i < LIMIT; i++) begin
            #1;
            checkOutput($sformatf("blk%0d_pop4", i),    8'(pop4),    8'd0);
            checkOutput($sformatf("blk%0d_blocked", i), 8'(blocked), 8'd0);
            @(negedge CLK);
        end
        #1;
        checkOutput("blk_limit_blocked", 8'(blocked), 8'd1);
        checkOutput("blk_limit_state",   8'(state),   8'd3);
        @(negedge CLK);
        #1;
        checkOutput("blk_sat_blocked", 8'(blocked), 8'd1);
        fifo_af = 4'b0000;
        #1;
        checkOutput("blk_release_pop4", 8'(pop4), 8'd1);
        @(negedge CLK);
        #1;
        checkOutput("blk_clear_blocked", 8'(blocked), 8'd0);

        // Asynchronous reset in the middle of active transfers.
        fifo_empty = 4'b0000;
        out_ready  = 1'b1;
        #1;
        checkOutput("mid_pop4_before",   8'(pop4),      8'd1);
        checkOutput("mid_pop_before",    8'(pop != 0),  8'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_pop4_after",  8'(pop4),   8'd0);
        checkOutput("mid_pop_after",   8'(pop),    8'd0);
        checkOutput("mid_state_after", 8'(state),  8'd0);
        checkOutput("mid_umb_af",      8'(umb_af), 8'd6);
        checkOutput("mid_umb_ae",      8'(umb_ae), 8'd1);
        @(negedge CLK);
        reset = 1'b1;
        modelReset();

        // Randomized traffic against the behavioural model. Destination and
        // almost-full flags change only occasionally so stalls build up.
        for (int n = 0; n < 1500; n++) begin
            init      = ($urandom_range(0, 15) == 0);
            umb_af_in = 3'($urandom_range(0, 7));
            umb_ae_in = 3'($urandom_range(0, 7));
            fifo4_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) fifo4_dest = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) fifo_af = 4'($urandom_range(0, 15));
            fifo_empty = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            modelExpect(ep4, ep, gi);
            checkOutput("rnd_pop4",    8'(pop4),    8'(ep4));
            checkOutput("rnd_pop",     8'(pop),     8'(ep));
            checkOutput("rnd_state",   8'(state),   8'(m_state));
            checkOutput("rnd_idle",    8'(IDLE),    8'(m_state == 2));
            checkOutput("rnd_umb_af",  8'(umb_af),  8'(m_af));
            checkOutput("rnd_umb_ae",  8'(umb_ae),  8'(m_ae));
            checkOutput("rnd_cfg_err", 8'(cfg_err), 8'(m_cfg));
            checkOutput("rnd_blocked", 8'(blocked), 8'(m_blocked));
            modelStep(ep4, gi);
            @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
